mult_arbiter: RTL



---
 rtl/mult_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mult_arbiter.sv
// Two-requester round-robin front end for a shared sequential multiplier.
// Latches the winner's operands, drives the multiplier start handshake, returns the
// product tagged with the owning requester, and aborts operations that exceed TIMEOUT.
module mult_arbiter #(
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic               Clk,
    input  logic               Rst,
    input  logic               Req0,
    input  logic [WIDTH-1:0]   A0,
    input  logic [WIDTH-1:0]   B0,
    input  logic               Req1,
    input  logic [WIDTH-1:0]   A1,
    input  logic [WIDTH-1:0]   B1,
    output logic               Gnt0,
    output logic               Gnt1,
    output logic               Rsp_Valid0,
    output logic               Rsp_Valid1,
    output logic [2*WIDTH-1:0] Rsp_R,
    output logic               Err,
    output logic               Busy,
    output logic               M_St,
    output logic [WIDTH-1:0]   M_A,
    output logic [WIDTH-1:0]   M_B,
    input  logic [2*WIDTH-1:0] M_R,
    input  logic               M_Idle,
    input  logic               M_Done
);

    localparam int unsigned   TW    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLast = TW'(TIMEOUT - 1);

    typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

    state_e             state_q, state_d;
    logic               gnt0_q, gnt0_d, gnt1_q, gnt1_d;
    logic               vld0_q, vld0_d, vld1_q, vld1_d;
    logic               err_q, err_d, busy_q, busy_d, st_q, st_d;
    logic [WIDTH-1:0]   ma_q, ma_d, mb_q, mb_d;
    logic [2*WIDTH-1:0] rsp_q, rsp_d;
    logic               owner_q, owner_d;
    // Requester that wins the next tie; flips away from each winner.
    logic               prio_q, prio_d;
    logic [TW-1:0]      timer_q, timer_d;
    logic               win;

    // Next-state logic: arbitration in IDLE, start handshake, completion and watchdog.
    always_comb begin
        state_d = state_q;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        vld0_d  = 1'b0;
        vld1_d  = 1'b0;
        err_d   = 1'b0;
        st_d    = st_q;
        ma_d    = ma_q;
        mb_d    = mb_q;
        rsp_d   = rsp_q;
        owner_d = owner_q;
        prio_d  = prio_q;
        timer_d = timer_q;
        win     = 1'b0;
        case (state_q)
            StIdle: begin
                if (Req0 || Req1) begin
                    win     = (Req0 && Req1) ? prio_q : Req1;
                    owner_d = win;
                    prio_d  = ~win;
                    ma_d    = win ? A1 : A0;
                    mb_d    = win ? B1 : B0;
                    gnt0_d  = ~win;
                    gnt1_d  = win;
                    st_d    = 1'b1;
                    timer_d = '0;
                    state_d = StStart;
                end
            end
            StStart, StWait: begin
                timer_d = timer_q + TW'(1);
                // Done wins over the watchdog; a done seen in START is a fast completion.
                if (M_Done) begin
                    rsp_d   = M_R;
                    vld0_d  = ~owner_q;
                    vld1_d  = owner_q;
                    st_d    = 1'b0;
                    state_d = StIdle;
                end else if (timer_q == TLast) begin
                    rsp_d   = '0;
                    err_d   = 1'b1;
                    vld0_d  = ~owner_q;
                    vld1_d  = owner_q;
                    st_d    = 1'b0;
                    state_d = StIdle;
                end else if (state_q == StStart && !M_Idle) begin
                    st_d    = 1'b0;
                    state_d = StWait;
                end
            end
            default: state_d = StIdle;
        endcase
        busy_d = (state_d != StIdle);
    end

    // State and registered outputs; async reset drops any in-flight operation silently.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= StIdle;
            gnt0_q  <= 1'b0;
            gnt1_q  <= 1'b0;
            vld0_q  <= 1'b0;
            vld1_q  <= 1'b0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            st_q    <= 1'b0;
            ma_q    <= '0;
            mb_q    <= '0;
            rsp_q   <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            timer_q <= '0;
        end else begin
            state_q <= state_d;
            gnt0_q  <= gnt0_d;
            gnt1_q  <= gnt1_d;
            vld0_q  <= vld0_d;
            vld1_q  <= vld1_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            st_q    <= st_d;
            ma_q    <= ma_d;
            mb_q    <= mb_d;
            rsp_q   <= rsp_d;
            owner_q <= owner_d;
            prio_q  <= prio_d;
            timer_q <= timer_d;
        end
    end

    assign Gnt0       = gnt0_q;
    assign Gnt1       = gnt1_q;
    assign Rsp_Valid0 = vld0_q;
    assign Rsp_Valid1 = vld1_q;
    assign Rsp_R      = rsp_q;
    assign Err        = err_q;
    assign Busy       = busy_q;
    assign M_St       = st_q;
    assign M_A        = ma_q;
    assign M_B        = mb_q;

endmodule
